// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe game controller.
package ttt_pkg;

  // Cell encodings on the packed 18-bit board
  localparam logic [1:0] EMPTY  = 2'b00;
  localparam logic [1:0] MARK_X = 2'b01;
  localparam logic [1:0] MARK_O = 2'b10;

  // Status codes seen by the renderer
  localparam logic [1:0] STAT_PLAY  = 2'b00;
  localparam logic [1:0] STAT_WIN_X = 2'b01;
  localparam logic [1:0] STAT_WIN_O = 2'b10;
  localparam logic [1:0] STAT_DRAW  = 2'b11;

  localparam logic [3:0] CURSOR_HOME = 4'd4;
  localparam logic [3:0] CELLS       = 4'd9;

  // Line index -> three cell indices; order matches win_line bit order
  localparam logic [3:0] LINE_TBL [8][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  typedef enum logic [2:0] {
    S_PLAY,
    S_CHECK,
    S_WIN_X,
    S_WIN_O,
    S_DRAW
  } state_e;

  // Read one cell; indices outside 0..8 read as empty
  function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] idx);
    cell_at = EMPTY;
    for (int i = 0; i < 9; i++) begin
      if (idx == 4'(i)) cell_at = b[2*i +: 2];
    end
  endfunction

endpackage

// File: rtl/ttt_game_ctrl_btn_debounce.sv
// One button: 2-flop synchronizer, debounce counter, one-cycle press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [1:0]       sync;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] cnt;

  // Synchronize, count mismatch cycles, flip stable level, emit rising-edge pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync     <= 2'b00;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      cnt      <= '0;
      pulse    <= 1'b0;
    end else begin
      sync     <= {sync[0], raw};
      stable_d <= stable;
      pulse    <= stable & ~stable_d;
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game state: button conditioning, cursor, marks, win/draw detection.
// Handshake note: buttons are fire-and-forget pulses; there is no backpressure,
// a pulse is either consumed in its cycle or dropped.
module ttt_game_ctrl
  import ttt_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic        dclk,
  input  logic        rst_n,
  input  logic        btns,
  input  logic        btnu,
  input  logic        btnd,
  input  logic        btnl,
  input  logic        btnr,
  output logic [17:0] board,
  output logic [3:0]  cursor,
  output logic        turn,
  output logic [1:0]  status,
  output logic [7:0]  win_line,
  output logic [3:0]  move_count
);

  logic   p_s, p_u, p_d, p_l, p_r;
  logic   act_sel, act_up, act_dn, act_lt, act_rt;
  logic   cell_empty;
  logic [3:0] cur_up, cur_dn, cur_lt, cur_rt;
  logic [7:0] x_lines, o_lines;
  state_e state, state_nxt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_s (.clk(dclk), .rst_n(rst_n), .raw(btns), .pulse(p_s));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_u (.clk(dclk), .rst_n(rst_n), .raw(btnu), .pulse(p_u));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_d (.clk(dclk), .rst_n(rst_n), .raw(btnd), .pulse(p_d));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_l (.clk(dclk), .rst_n(rst_n), .raw(btnl), .pulse(p_l));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_r (.clk(dclk), .rst_n(rst_n), .raw(btnr), .pulse(p_r));

  // Fixed-priority arbitration; losers are dropped
  always_comb begin
    act_sel = p_s;
    act_up  = p_u & ~p_s;
    act_dn  = p_d & ~p_s & ~p_u;
    act_lt  = p_l & ~p_s & ~p_u & ~p_d;
    act_rt  = p_r & ~p_s & ~p_u & ~p_d & ~p_l;
  end

  // Wrapped cursor targets and occupancy of the cursor cell
  always_comb begin
    cur_up     = (cursor < 4'd3) ? cursor + 4'd6 : cursor - 4'd3;
    cur_dn     = (cursor > 4'd5) ? cursor - 4'd6 : cursor + 4'd3;
    cur_lt     = (cursor == 4'd0 || cursor == 4'd3 || cursor == 4'd6) ? cursor + 4'd2 : cursor - 4'd1;
    cur_rt     = (cursor == 4'd2 || cursor == 4'd5 || cursor == 4'd8) ? cursor - 4'd2 : cursor + 4'd1;
    cell_empty = (cell_at(board, cursor) == EMPTY);
  end

  // Line completion for each player on the current board
  always_comb begin
    x_lines = '0;
    o_lines = '0;
    for (int l = 0; l < 8; l++) begin
      x_lines[l] = (cell_at(board, LINE_TBL[l][0]) == MARK_X) &&
                   (cell_at(board, LINE_TBL[l][1]) == MARK_X) &&
                   (cell_at(board, LINE_TBL[l][2]) == MARK_X);
      o_lines[l] = (cell_at(board, LINE_TBL[l][0]) == MARK_O) &&
                   (cell_at(board, LINE_TBL[l][1]) == MARK_O) &&
                   (cell_at(board, LINE_TBL[l][2]) == MARK_O);
    end
  end

  // FSM state register
  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) state <= S_PLAY;
    else        state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_PLAY:  if (act_sel && cell_empty) state_nxt = S_CHECK;
      S_CHECK: begin
        if (|x_lines)                 state_nxt = S_WIN_X;
        else if (|o_lines)            state_nxt = S_WIN_O;
        else if (move_count == CELLS) state_nxt = S_DRAW;
        else                          state_nxt = S_PLAY;
      end
      S_WIN_X, S_WIN_O, S_DRAW: if (act_sel) state_nxt = S_PLAY;
      default: state_nxt = S_PLAY;
    endcase
  end

  // FSM output decode; CHECK reads as PLAY
  always_comb begin
    status = STAT_PLAY;
    case (state)
      S_WIN_X: status = STAT_WIN_X;
      S_WIN_O: status = STAT_WIN_O;
      S_DRAW:  status = STAT_DRAW;
      default: status = STAT_PLAY;
    endcase
  end

  // Board, cursor, turn, win line and move count updates
  always_ff @(posedge dclk or negedge rst_n) begin
    if (!rst_n) begin
      board      <= '0;
      cursor     <= CURSOR_HOME;
      turn       <= 1'b0;
      win_line   <= '0;
      move_count <= '0;
    end else begin
      case (state)
        S_PLAY: begin
          if (act_sel) begin
            if (cell_empty) begin
              for (int i = 0; i < 9; i++) begin
                if (cursor == 4'(i)) board[2*i +: 2] <= turn ? MARK_O : MARK_X;
              end
              move_count <= move_count + 4'd1;
            end
          end else if (act_up) begin
            cursor <= cur_up;
          end else if (act_dn) begin
            cursor <= cur_dn;
          end else if (act_lt) begin
            cursor <= cur_lt;
          end else if (act_rt) begin
            cursor <= cur_rt;
          end
        end
        S_CHECK: begin
          if (|x_lines)                 win_line <= x_lines;
          else if (|o_lines)            win_line <= o_lines;
          else if (move_count != CELLS) turn     <= ~turn;
        end
        S_WIN_X, S_WIN_O, S_DRAW: begin
          if (act_sel) begin
            board      <= '0;
            cursor     <= CURSOR_HOME;
            turn       <= 1'b0;
            win_line   <= '0;
            move_count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for ttt_game_ctrl with short debounce.
module tb_ttt_game_ctrl;

  logic        dclk = 1'b0;
  logic        rst_n;
  logic        btns, btnu, btnd, btnl, btnr;
  logic [17:0] board;
  logic [3:0]  cursor;
  logic        turn;
  logic [1:0]  status;
  logic [7:0]  win_line;
  logic [3:0]  move_count;

  int total = 0;
  int bad   = 0;

  localparam logic [4:0] B_S = 5'b10000;
  localparam logic [4:0] B_U = 5'b01000;
  localparam logic [4:0] B_D = 5'b00100;
  localparam logic [4:0] B_L = 5'b00010;
  localparam logic [4:0] B_R = 5'b00001;

  ttt_game_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .dclk(dclk), .rst_n(rst_n),
    .btns(btns), .btnu(btnu), .btnd(btnd), .btnl(btnl), .btnr(btnr),
    .board(board), .cursor(cursor), .turn(turn), .status(status),
    .win_line(win_line), .move_count(move_count)
  );

  // clock / reset
  always #5 dclk = ~dclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [4:0] m);
    {btns, btnu, btnd, btnl, btnr} = m;
  endtask

  // hold buttons long enough to debounce the press and the release
  task automatic press(input logic [4:0] m);
    drive(m);
    repeat (12) @(negedge dclk);
    drive(5'b0);
    repeat (12) @(negedge dclk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_board"}, 32'(board), 32'h0);
    check({tag, "_cursor"}, 32'(cursor), 32'd4);
    check({tag, "_turn"}, 32'(turn), 32'd0);
    check({tag, "_status"}, 32'(status), 32'd0);
    check({tag, "_winline"}, 32'(win_line), 32'd0);
    check({tag, "_mc"}, 32'(move_count), 32'd0);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0;
    drive(5'b0);
    repeat (3) @(negedge dclk);
    rst_n = 1'b1;
    repeat (2) @(negedge dclk);
    check_reset_vals("reset");

    // bounce rejection on btnr
    for (int i = 0; i < 5; i++) begin
      btnr = 1'b1; repeat (2) @(negedge dclk);
      btnr = 1'b0; repeat (2) @(negedge dclk);
    end
    btnr = 1'b1;
    repeat (10) @(negedge dclk);
    check("bounce_cursor", 32'(cursor), 32'd5);
    btnr = 1'b0;
    repeat (12) @(negedge dclk);
    check("bounce_release", 32'(cursor), 32'd5);
    check("bounce_mc", 32'(move_count), 32'd0);

    // cursor wrap
    press(B_L); check("left_5_4", 32'(cursor), 32'd4);
    press(B_U); check("up_4_1", 32'(cursor), 32'd1);
    press(B_U); check("up_wrap_1_7", 32'(cursor), 32'd7);
    press(B_L); check("left_7_6", 32'(cursor), 32'd6);
    press(B_U); check("up_6_3", 32'(cursor), 32'd3);
    press(B_L); check("left_wrap_3_5", 32'(cursor), 32'd5);
    press(B_R); check("right_wrap_5_3", 32'(cursor), 32'd3);
    press(B_D); check("down_3_6", 32'(cursor), 32'd6);
    press(B_D); check("down_wrap_6_0", 32'(cursor), 32'd0);

    // select beats right in the same cycle: X at 0
    press(B_S | B_R);
    check("prio_board", 32'(board), 32'h00001);
    check("prio_cursor", 32'(cursor), 32'd0);
    check("prio_turn", 32'(turn), 32'd1);

    // win for X on row 0: O3, X1, O4, X2
    press(B_D); press(B_S);
    press(B_U); press(B_R); press(B_S);
    press(B_D); press(B_S);
    check("pre_win_status", 32'(status), 32'd0);
    press(B_U); press(B_R);
    check("pre_win_cursor", 32'(cursor), 32'd2);
    press(B_S);
    check("win_status", 32'(status), 32'd1);
    check("win_line", 32'(win_line), 32'h01);
    check("win_turn", 32'(turn), 32'd0);
    check("win_board", 32'(board), 32'h00295);
    check("win_mc", 32'(move_count), 32'd5);
    press(B_U);
    check("win_up_cursor", 32'(cursor), 32'd2);
    check("win_up_status", 32'(status), 32'd1);
    press(B_S);
    check_reset_vals("newgame");

    // occupied cell ignored
    press(B_S);
    press(B_S);
    check("occ_board", 32'(board), 32'h00100);
    check("occ_turn", 32'(turn), 32'd1);
    check("occ_mc", 32'(move_count), 32'd1);
    check("occ_status", 32'(status), 32'd0);

    // reset asserted while in CHECK after O places at cell 1
    press(B_U);
    btns = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge dclk);
      if (move_count == 4'd2) seen = 1'b1;
    end
    check("midrst_wait", 32'(seen), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrst_low");
    btns = 1'b0;
    repeat (3) @(negedge dclk);
    rst_n = 1'b1;
    repeat (2) @(negedge dclk);
    check_reset_vals("midrst_rel");

    // draw: X0 O1 X2 O4 X3 O5 X7 O6 X8
    press(B_U); press(B_L); press(B_S);
    press(B_R); press(B_S);
    press(B_R); press(B_S);
    press(B_D); press(B_L); press(B_S);
    press(B_L); press(B_S);
    press(B_R); press(B_R); press(B_S);
    press(B_D); press(B_L); press(B_S);
    press(B_L); press(B_S);
    check("pre_draw_status", 32'(status), 32'd0);
    press(B_R); press(B_R); press(B_S);
    check("draw_status", 32'(status), 32'd3);
    check("draw_winline", 32'(win_line), 32'd0);
    check("draw_mc", 32'(move_count), 32'd9);
    check("draw_board", 32'(board), 32'h16A59);
    check("draw_turn", 32'(turn), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ttt_game_ctrl.md
# ttt_game_ctrl

Game-state controller for the tic-tac-toe design. Conditions the five raw board buttons, moves a 3×3 cursor, places alternating X/O marks, and detects win and draw. Sits directly upstream of the VGA renderer: its registered board, cursor and status outputs are what the renderer draws. Runs in the `dclk` domain so the renderer consumes its outputs without crossing clock domains.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: cycles a synchronized button must hold its new level before it is accepted (20 ms at 25 MHz).
- `CNT_W`, default 19: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

- `dclk` in 1: display clock, all logic rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `btns`, `btnu`, `btnd`, `btnl`, `btnr` in 1 each: raw, asynchronous, bouncing buttons (select, up, down, left, right).
- `board` out 18: cell i occupies bits [2i+1:2i]. Encoding: 00 empty, 01 X, 10 O. Cell index = row*3 + col.
- `cursor` out 4: selected cell, 0–8.
- `turn` out 1: 0 = X to move, 1 = O to move.
- `status` out 2: 00 PLAY, 01 WIN_X, 10 WIN_O, 11 DRAW.
- `win_line` out 8: one-hot winning line. Bits 0–2 are rows 0–2, bits 3–5 are cols 0–2, bit 6 is diagonal 0/4/8, bit 7 is anti-diagonal 2/4/6. Zero unless status is WIN_*.
- `move_count` out 4: marks placed, 0–9.

## Operation
- **Synchronization:** each button passes through a 2-flop synchronizer.
- **Debounce:**
  - Counter clears whenever the synchronized level equals the stable level.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES, the stable level flips and the counter clears.
  - A stable 0→1 transition produces a one-cycle press pulse. Releases produce nothing.
- **Arbitration:** at most one action per cycle. Priority is btns > btnu > btnd > btnl > btnr. Lower-priority pulses in the same cycle are dropped, not queued.
- **Cursor movement** (PLAY only; wraps within the grid):
  - up: row 0→2, else −3.
  - down: row 2→0, else +3.
  - left: col 0→2, else −1.
  - right: col 2→0, else +1.
- **FSM states:** PLAY, CHECK, WIN_X, WIN_O, DRAW.
  - **PLAY + btns on an empty cell:** write mark (01 if turn=0, else 10), increment move_count, go to CHECK.
  - **PLAY + btns on an occupied cell:** ignored; no state change.
  - **CHECK (exactly one cycle):** evaluate all 8 lines on the updated board. Any line all X → WIN_X. Any line all O → WIN_O. Otherwise move_count==9 → DRAW. Otherwise toggle turn and return to PLAY. All button pulses arriving during CHECK are dropped. `status` reads 00 while in CHECK.
  - **WIN_X / WIN_O / DRAW:** directional presses ignored. btns starts a new game: board=0, cursor=4, turn=0, move_count=0, win_line=0, next state PLAY.
- Turn is not toggled on a win or a draw.
- **Reset values:** board=0, cursor=4, turn=0, status=00, win_line=0, move_count=0. Synchronizers, stable levels and counters are 0, and the FSM is in PLAY.
- **Reset mid-operation:** all state returns immediately to reset values, including in-flight debounce counts.

## Timing
- Raw edge to synchronized level: 2 cycles.
- Synchronized level held for DEBOUNCE_CYCLES cycles → stable flip. Press pulse is registered in the following cycle.
- Pulse cycle N → board, cursor and move_count updated at N+1.
- status, win_line and turn are updated at N+2 (end of CHECK).
- All outputs are registered, with no combinational path from inputs.

## Structure
- **Package `ttt_pkg`:**
  - cell encodings (EMPTY, MARK_X, MARK_O)
  - status codes
  - the 8×3 line-to-cell index table
  - CURSOR_HOME = 4
  - FSM state enum
- **Sub-module `btn_debounce`:** synchronizer, debounce counter and rising-edge pulse for one button, parameterized by DEBOUNCE_CYCLES/CNT_W. Instantiated five times.

## Test plan
Bench uses DEBOUNCE_CYCLES=4, CNT_W=3.
- **Reset:** release rst_n → board=0, cursor=4, turn=0, status=00, move_count=0.
- **Bounce rejection:** btnr toggles every 2 cycles for 20 cycles, then held high 10 cycles → exactly one move, cursor 4→5. Release adds no move.
- **Wrap and priority:**
  - From 4: up, up → 1, then 7.
  - From 3: left → 5.
  - btns and btnr pulsed in the same cycle → mark placed, cursor unchanged.
- **Win:** moves X0, O3, X1, O4, X2 → status=01, win_line=8'h01, turn=0. Then btnu → no change. Then btns → board=0, cursor=4, status=00.
- **Occupied cell:** btns twice at cell 4 → board=18'h00100 (X in cell 4), turn=1, move_count=1 after the second press.
- **Draw:** X0, O1, X2, O4, X3, O5, X7, O6, X8 → status=11, win_line=0, move_count=9.
- **Mid-game reset:** assert rst_n low during CHECK → all outputs return to reset values.
